instr_sequencer: RTL



---
 rtl/instr_sequencer_pkg.sv | 32 +++
 rtl/instr_sequencer.sv | 70 +++++++
 2 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared CPU constants: sequencer states, halt encoding, opcode and ALU-op fields.
package instr_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } seq_state_e;

   localparam logic [15:0] HALT_INSTR_DEF = 16'hFFFF;

   // Opcode lives in the top nibble of the instruction word.
   typedef enum logic [3:0] {
      OP_ADD  = 4'h0,
      OP_SUB  = 4'h1,
      OP_AND  = 4'h2,
      OP_OR   = 4'h3,
      OP_MOV  = 4'h4,
      OP_SHOW = 4'h5
   } opcode_e;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_AND = 2'd2,
      ALU_OR  = 2'd3
   } alu_op_e;

endpackage

// File: rtl/instr_sequencer.sv
// Instruction sequencer: IDLE/FETCH/DECODE/EXEC/WB/HALT control FSM owning PC and IR.
// Strobes decode from registered state; decoder flags gate them during EXEC/WB.
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter int          PC_W       = 8,
   parameter logic [15:0] HALT_INSTR = HALT_INSTR_DEF
) (
   input  logic            i_CLK,
   input  logic            i_RSTn,
   input  logic            i_Run,
   input  logic            i_StepMode,
   input  logic            i_Step,
   output logic            o_FetchReq,
   output logic [PC_W-1:0] o_PC,
   input  logic            i_FetchAck,
   input  logic [15:0]     i_Instr,
   output logic [15:0]     o_IR,
   input  logic            i_WriteBack,
   input  logic            i_ShowR1,
   output logic            o_ExecEn,
   output logic            o_RegWrEn,
   output logic            o_ShowEn,
   output logic            o_Halted
);

   seq_state_e      state_q;
   logic [PC_W-1:0] pc_q;
   logic [15:0]     ir_q;

   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE:
               if (i_Run && (!i_StepMode || i_Step)) state_q <= S_FETCH;
            S_FETCH:
               if (i_FetchAck) begin
                  ir_q    <= i_Instr;
                  state_q <= S_DECODE;
               end
            S_DECODE:
               state_q <= (ir_q == HALT_INSTR) ? S_HALT : S_EXEC;
            S_EXEC:
               state_q <= S_WB;
            S_WB: begin
               // PC wraps naturally at 2^PC_W.
               pc_q    <= pc_q + PC_W'(1);
               state_q <= (i_Run && !i_StepMode) ? S_FETCH : S_IDLE;
            end
            S_HALT:
               state_q <= S_HALT;
            default:
               state_q <= S_IDLE;
         endcase
      end
   end

   assign o_PC       = pc_q;
   assign o_IR       = ir_q;
   assign o_FetchReq = (state_q == S_FETCH);
   assign o_ExecEn   = (state_q == S_EXEC);
   assign o_ShowEn   = (state_q == S_EXEC) && i_ShowR1;
   assign o_RegWrEn  = (state_q == S_WB) && i_WriteBack;
   assign o_Halted   = (state_q == S_HALT);

endmodule
